// File: rtl/avl_bus_type_pkg.sv
// Shared types for the i_avl_bus fabric: burst FSM states and burst-count width.
// Imported by the bus interface and by every slave on the fabric.
package avl_bus_type;

    localparam int ALV_BURST_MAX_COUNT = 255;
    localparam int BURST_CNT_W = $clog2(ALV_BURST_MAX_COUNT + 1);

    typedef enum logic [0:0] {
        BURST_IDLE   = 1'b0,
        BURST_ACTIVE = 1'b1
    } burst_state_t;

endpackage

// File: rtl/i_avl_bus.sv
// Avalon-style bus bundle with in-order read responses and master back-pressure.
// The slave modport is what on-chip memory targets connect to.
interface i_avl_bus;

    logic [31:0] address;
    logic [3:0]  byte_en;
    logic        read;
    logic        write;
    logic [31:0] write_data;
    logic        begin_burst_transfer;
    logic [avl_bus_type::BURST_CNT_W-1:0] burst_count;
    logic        resp_ready;
    logic        request_ready;
    logic [31:0] read_data;
    logic        read_data_valid;

    modport slave (
        input  address, byte_en, read, write, write_data,
        input  begin_burst_transfer, burst_count, resp_ready,
        output request_ready, read_data, read_data_valid
    );

    modport master (
        output address, byte_en, read, write, write_data,
        output begin_burst_transfer, burst_count, resp_ready,
        input  request_ready, read_data, read_data_valid
    );

endinterface

// File: rtl/avl_resp_fifo.sv
// Small synchronous FIFO for in-order bus responses; dout reads 0 when empty.
// DEPTH must be a power of two and at least 2.
module avl_resp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign dout    = (count != '0) ? mem[rd_ptr] : '0;

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/avl_bus_ram_slave.sv
// Word-organised RAM slave on i_avl_bus with byte-enable writes and burst support.
// Optional sticky protocol checker and err port: define AVL_RAM_SLAVE_ERR_EN.
module avl_bus_ram_slave
    import avl_bus_type::*;
#(
    parameter logic [31:0] ADDR_BASE       = 32'h0000_0000,
    parameter int          MEM_WORDS       = 1024,
    parameter int          RESP_FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rest,
    i_avl_bus.slave   avl_s
`ifdef AVL_RAM_SLAVE_ERR_EN
    ,
    output logic      err
`endif
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(RESP_FIFO_DEPTH) + 1;

    logic [31:0]            mem [MEM_WORDS];

    burst_state_t           state;
    logic [31:0]            addr_q;
    logic [BURST_CNT_W-1:0] remain;
    logic                   burst_wr;

    logic                   pend_valid;
    logic [31:0]            pend_data;

    logic [CNT_W-1:0]       fifo_count;
    logic [31:0]            fifo_dout;
    logic [CNT_W:0]         credit_used;

    logic                   accept;
    logic                   in_burst;
    logic                   beat_wr;
    logic [31:0]            beat_addr;
    logic [IDX_W-1:0]       idx;
    logic                   pop;

    assign in_burst  = (state == BURST_ACTIVE);
    assign accept    = (avl_s.read || avl_s.write) && avl_s.request_ready;
    assign beat_addr = in_burst ? (addr_q + 32'd4) : avl_s.address;
    assign beat_wr   = in_burst ? burst_wr : avl_s.write;
    assign idx       = IDX_W'((beat_addr - ADDR_BASE) >> 2);

    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pend_valid};
    assign avl_s.request_ready = credit_used < (CNT_W + 1)'(RESP_FIFO_DEPTH);

    assign avl_s.read_data_valid = (fifo_count != '0);
    assign avl_s.read_data       = fifo_dout;
    assign pop = avl_s.read_data_valid && avl_s.resp_ready;

    // Burst tracking: first beat latches address/length/type, later beats step by 4.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state    <= BURST_IDLE;
            addr_q   <= '0;
            remain   <= '0;
            burst_wr <= 1'b0;
        end else if (accept) begin
            if (!in_burst) begin
                if (avl_s.begin_burst_transfer && (avl_s.burst_count != '0)) begin
                    state    <= BURST_ACTIVE;
                    addr_q   <= avl_s.address;
                    remain   <= avl_s.burst_count;
                    burst_wr <= avl_s.write;
                end
            end else begin
                addr_q <= addr_q + 32'd4;
                remain <= remain - 1'b1;
                if (remain == BURST_CNT_W'(1)) state <= BURST_IDLE;
            end
        end
    end

    // RAM port: byte-lane writes and synchronous read into the pending stage.
    always_ff @(posedge clk) begin
        if (accept && beat_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (avl_s.byte_en[i]) mem[idx][8*i +: 8] <= avl_s.write_data[8*i +: 8];
            end
        end
        if (accept && !beat_wr) pend_data <= mem[idx];
    end

    // Pending stage flag; its data moves into the FIFO on the following edge.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) pend_valid <= 1'b0;
        else       pend_valid <= accept && !beat_wr;
    end

    avl_resp_fifo #(
        .WIDTH (32),
        .DEPTH (RESP_FIFO_DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .rst_n (rest),
        .push  (pend_valid),
        .pop   (pop),
        .din   (pend_data),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

`ifdef AVL_RAM_SLAVE_ERR_EN
    logic err_hit;

    assign err_hit = accept && (
        (avl_s.read && avl_s.write) ||
        (in_burst && ((avl_s.address != addr_q + 32'd4) ||
                      avl_s.begin_burst_transfer ||
                      (avl_s.write != burst_wr))));

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest)        err <= 1'b0;
        else if (err_hit) err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_avl_bus_ram_slave.sv
// Directed bench for avl_bus_ram_slave plus a short scoreboarded random run.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_avl_bus_ram_slave;
    import avl_bus_type::*;

    logic clk = 1'b0;
    logic rest = 1'b0;

    always #5 clk = ~clk;

    i_avl_bus avl();

`ifdef AVL_RAM_SLAVE_ERR_EN
    logic err;
`endif

    avl_bus_ram_slave #(
        .ADDR_BASE       (32'h0000_0000),
        .MEM_WORDS       (1024),
        .RESP_FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rest  (rest),
        .avl_s (avl)
`ifdef AVL_RAM_SLAVE_ERR_EN
        ,
        .err   (err)
`endif
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        mon_en   = 1'b0;
    logic [31:0] model [0:1023];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         input logic bb, input logic [BURST_CNT_W-1:0] bc);
        int t;
        t = 0;
        avl.read = rd;
        avl.write = wr;
        avl.address = a;
        avl.write_data = d;
        avl.byte_en = be;
        avl.begin_burst_transfer = bb;
        avl.burst_count = bc;
        while (!avl.request_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        avl.read = 1'b0;
        avl.write = 1'b0;
        avl.begin_burst_transfer = 1'b0;
    endtask

    task automatic read_word(input logic [31:0] a, output logic [31:0] d);
        int t;
        t = 0;
        avl.resp_ready = 1'b1;
        issue(1'b1, 1'b0, a, 32'd0, 4'hF, 1'b0, '0);
        while (!avl.read_data_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rd_valid", {31'd0, avl.read_data_valid}, 32'd1);
        d = avl.read_data;
        @(negedge clk);
    endtask

    // Random-phase response monitor: chooses resp_ready and checks each pop.
    always @(negedge clk) begin
        if (mon_en) begin
            avl.resp_ready = 1'($urandom_range(0, 1));
            if (avl.resp_ready && avl.read_data_valid) begin
                if (exp_q.size() == 0) check("spurious_resp", 32'd1, 32'd0);
                else check("rand_rd", avl.read_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          t;

        avl.read = 1'b0;
        avl.write = 1'b0;
        avl.address = '0;
        avl.write_data = '0;
        avl.byte_en = '0;
        avl.begin_burst_transfer = 1'b0;
        avl.burst_count = '0;
        avl.resp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, avl.request_ready}, 32'd1);
        check("rst_valid", {31'd0, avl.read_data_valid}, 32'd0);
        check("rst_data", avl.read_data, 32'd0);
`ifdef AVL_RAM_SLAVE_ERR_EN
        check("rst_err", {31'd0, err}, 32'd0);
`endif
        rest = 1'b1;
        @(negedge clk);

        // Byte-enable merge and read latency
        issue(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, '0);
        issue(1'b0, 1'b1, 32'h10, 32'h0000_00AA, 4'h1, 1'b0, '0);
        avl.resp_ready = 1'b0;
        issue(1'b1, 1'b0, 32'h10, 32'd0, 4'hF, 1'b0, '0);
        check("lat_edge_n", {31'd0, avl.read_data_valid}, 32'd0);
        @(negedge clk);
        check("lat_edge_n1", {31'd0, avl.read_data_valid}, 32'd1);
        check("be_merge", avl.read_data, 32'hDEAD_BEAA);
        avl.resp_ready = 1'b1;
        @(negedge clk);
        check("pop_empty", {31'd0, avl.read_data_valid}, 32'd0);

        // Write burst, incoming addresses wrong after beat 0
        issue(1'b0, 1'b1, 32'h100, 32'd1, 4'hF, 1'b1, BURST_CNT_W'(3));
        issue(1'b0, 1'b1, 32'hDEAD_0000, 32'd2, 4'hF, 1'b0, '0);
        issue(1'b0, 1'b1, 32'hDEAD_0000, 32'd3, 4'hF, 1'b0, '0);
        issue(1'b0, 1'b1, 32'hDEAD_0000, 32'd4, 4'hF, 1'b0, '0);
`ifdef AVL_RAM_SLAVE_ERR_EN
        check("err_addr", {31'd0, err}, 32'd1);
`endif
        for (int k = 0; k < 4; k++) begin
            read_word(32'h100 + 32'(4 * k), d);
            check("wburst", d, 32'(k + 1));
        end

        // Read burst with back-pressure fills the credit window
        avl.resp_ready = 1'b0;
        issue(1'b1, 1'b0, 32'h100, 32'd0, 4'hF, 1'b1, BURST_CNT_W'(3));
        issue(1'b1, 1'b0, 32'h104, 32'd0, 4'hF, 1'b0, '0);
        issue(1'b1, 1'b0, 32'h108, 32'd0, 4'hF, 1'b0, '0);
        issue(1'b1, 1'b0, 32'h10C, 32'd0, 4'hF, 1'b0, '0);
        check("ready_full", {31'd0, avl.request_ready}, 32'd0);
        avl.resp_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("rb_valid", {31'd0, avl.read_data_valid}, 32'd1);
            check("rb_data", avl.read_data, 32'(k));
            @(negedge clk);
        end
        check("rb_drained", {31'd0, avl.read_data_valid}, 32'd0);
        check("rb_ready", {31'd0, avl.request_ready}, 32'd1);

        // Out-of-window address aliases word 2
        issue(1'b0, 1'b1, 32'h0000_1008, 32'h55AA_1234, 4'hF, 1'b0, '0);
        read_word(32'h8, d);
        check("alias", d, 32'h55AA_1234);

        // Reset mid-burst with two responses queued
        issue(1'b0, 1'b1, 32'h300, 32'h1234_5678, 4'hF, 1'b0, '0);
        avl.resp_ready = 1'b0;
        issue(1'b1, 1'b0, 32'h200, 32'd0, 4'hF, 1'b1, BURST_CNT_W'(3));
        issue(1'b1, 1'b0, 32'h204, 32'd0, 4'hF, 1'b0, '0);
        @(negedge clk);
        check("pre_rst_valid", {31'd0, avl.read_data_valid}, 32'd1);
        rest = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, avl.read_data_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, avl.request_ready}, 32'd1);
        check("mid_rst_data", avl.read_data, 32'd0);
`ifdef AVL_RAM_SLAVE_ERR_EN
        check("mid_rst_err", {31'd0, err}, 32'd0);
`endif
        @(negedge clk);
        rest = 1'b1;
        @(negedge clk);
        read_word(32'h300, d);
        check("post_rst_rd", d, 32'h1234_5678);

        // Random single/burst traffic against the model
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            model[i] = d;
            issue(1'b0, 1'b1, 32'(4 * i), d, 4'hF, 1'b0, '0);
        end
        mon_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int          op;
            int          b;
            int          bc;
            int          beats;
            logic [3:0]  be;
            logic [31:0] wd;
            op = $urandom_range(0, 3);
            b  = $urandom_range(0, 60);
            bc = (op >= 2) ? $urandom_range(1, 3) : $urandom_range(0, 3);
            beats = (op >= 2) ? bc : 0;
            for (int k = 0; k <= beats; k++) begin
                logic bb;
                bb = (op >= 2) && (k == 0);
                if (op[0] == 1'b0) begin
                    wd = $urandom;
                    be = 4'($urandom_range(0, 15));
                    issue(1'b0, 1'b1, 32'(4 * (b + k)), wd, be, bb, BURST_CNT_W'(bc));
                    for (int l = 0; l < 4; l++) begin
                        if (be[l]) model[b + k][8*l +: 8] = wd[8*l +: 8];
                    end
                end else begin
                    issue(1'b1, 1'b0, 32'(4 * (b + k)), 32'd0, 4'hF, bb, BURST_CNT_W'(bc));
                    exp_q.push_back(model[b + k]);
                end
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        t = 0;
        while ((exp_q.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("rand_drain", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        @(negedge clk);
        check("rand_no_extra", {31'd0, avl.read_data_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
